// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Operand-fetch stage sitting behind a 32x32 register file with
//             1-cycle synchronous read and no write-through. Drives the
//             regfile read addresses from decode, forwards writebacks that
//             the regfile read misses, holds operands while execute stalls
//             (keeping them coherent with later writebacks) and carries an
//             opaque payload alongside.
//  Ports    : clk, rst_n (sync, active low)
//             inValid/inReady/inRs1/inRs2/inPayload   - decode side
//             rdAddrA/rdAddrB/rdDataA/rdDataB         - regfile read ports
//             write/wrAddr/wrData                     - writeback snoop
//             flush                                   - pipeline flush
//             outValid/outReady/opA/opB/outPayload    - execute side
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [4:0]           inRs1,
    input  logic [4:0]           inRs2,
    input  logic [PAYLOAD_W-1:0] inPayload,
    output logic [4:0]           rdAddrA,
    output logic [4:0]           rdAddrB,
    input  logic [XLEN-1:0]      rdDataA,
    input  logic [XLEN-1:0]      rdDataB,
    input  logic                 write,
    input  logic [4:0]           wrAddr,
    input  logic [XLEN-1:0]      wrData,
    input  logic                 flush,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      opA,
    output logic [XLEN-1:0]      opB,
    output logic [PAYLOAD_W-1:0] outPayload
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FRESH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             rs1_q, rs1_d, rs2_q, rs2_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic                   fwdA_q, fwdA_d, fwdB_q, fwdB_d;
    logic [XLEN-1:0]        fwdDataA_q, fwdDataA_d, fwdDataB_q, fwdDataB_d;
    logic [XLEN-1:0]        heldA_q, heldA_d, heldB_q, heldB_d;

    logic                   w_eff;
    logic                   w_accept;
    logic [XLEN-1:0]        w_curA, w_curB;

    // The regfile samples these every edge; only accept edges are consumed.
    assign rdAddrA    = inRs1;
    assign rdAddrB    = inRs2;

    assign w_eff      = write && (wrAddr != 5'd0);
    assign inReady    = (state_q == S_EMPTY) || outReady;
    assign w_accept   = inValid && inReady;

    assign outValid   = (state_q != S_EMPTY);
    assign opA        = w_curA;
    assign opB        = w_curB;
    assign outPayload = payload_q;

    // Current operand values. In FRESH the regfile output is only correct if
    // no write to the same index landed on the accept edge (the regfile
    // returns pre-write data), hence the captured forward path.
    always_comb begin
        w_curA = '0;
        w_curB = '0;
        case (state_q)
            S_FRESH: begin
                w_curA = (rs1_q == 5'd0) ? '0 : (fwdA_q ? fwdDataA_q : rdDataA);
                w_curB = (rs2_q == 5'd0) ? '0 : (fwdB_q ? fwdDataB_q : rdDataB);
            end
            S_HELD: begin
                w_curA = heldA_q;
                w_curB = heldB_q;
            end
            default: begin
                w_curA = '0;
                w_curB = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        payload_d  = payload_q;
        fwdA_d     = fwdA_q;
        fwdB_d     = fwdB_q;
        fwdDataA_d = fwdDataA_q;
        fwdDataB_d = fwdDataB_q;
        heldA_d    = heldA_q;
        heldB_d    = heldB_q;

        if (flush) begin
            state_d = S_EMPTY;
        end else if (w_accept) begin
            // Covers both an accept into EMPTY and a handoff+accept.
            state_d    = S_FRESH;
            rs1_d      = inRs1;
            rs2_d      = inRs2;
            payload_d  = inPayload;
            fwdA_d     = w_eff && (wrAddr == inRs1);
            fwdB_d     = w_eff && (wrAddr == inRs2);
            fwdDataA_d = wrData;
            fwdDataB_d = wrData;
        end else if (state_q != S_EMPTY) begin
            if (outReady) begin
                state_d = S_EMPTY;
            end else begin
                // Stall: latch what is visible now, unless a writeback to the
                // same register lands on this edge - the later write wins.
                state_d = S_HELD;
                heldA_d = (w_eff && (wrAddr == rs1_q) && (rs1_q != 5'd0)) ? wrData : w_curA;
                heldB_d = (w_eff && (wrAddr == rs2_q) && (rs2_q != 5'd0)) ? wrData : w_curB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            rs1_q      <= '0;
            rs2_q      <= '0;
            payload_q  <= '0;
            fwdA_q     <= 1'b0;
            fwdB_q     <= 1'b0;
            fwdDataA_q <= '0;
            fwdDataB_q <= '0;
            heldA_q    <= '0;
            heldB_q    <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            payload_q  <= payload_d;
            fwdA_q     <= fwdA_d;
            fwdB_q     <= fwdB_d;
            fwdDataA_q <= fwdDataA_d;
            fwdDataB_q <= fwdDataB_d;
            heldA_q    <= heldA_d;
            heldB_q    <= heldB_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Purpose  : Directed self-checking bench for operand_fetch, with a small
//             behavioural regfile (sync read, no write-through, x0 fixed).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    localparam int XLEN      = 32;
    localparam int PAYLOAD_W = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 inValid;
    logic                 inReady;
    logic [4:0]           inRs1, inRs2;
    logic [PAYLOAD_W-1:0] inPayload;
    logic [4:0]           rdAddrA, rdAddrB;
    logic [XLEN-1:0]      rdDataA, rdDataB;
    logic                 write;
    logic [4:0]           wrAddr;
    logic [XLEN-1:0]      wrData;
    logic                 flush;
    logic                 outValid;
    logic                 outReady;
    logic [XLEN-1:0]      opA, opB;
    logic [PAYLOAD_W-1:0] outPayload;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .inRs1      (inRs1),
        .inRs2      (inRs2),
        .inPayload  (inPayload),
        .rdAddrA    (rdAddrA),
        .rdAddrB    (rdAddrB),
        .rdDataA    (rdDataA),
        .rdDataB    (rdDataB),
        .write      (write),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .flush      (flush),
        .outValid   (outValid),
        .outReady   (outReady),
        .opA        (opA),
        .opB        (opB),
        .outPayload (outPayload)
    );

    // Register file model: read returns the pre-write value on a same-edge write.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) begin
        rdDataA <= (rdAddrA == 5'd0) ? '0 : rf[rdAddrA];
        rdDataB <= (rdAddrB == 5'd0) ? '0 : rf[rdAddrB];
        if (write && wrAddr != 5'd0) rf[wrAddr] <= wrData;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [XLEN-1:0] pre_val [9];
    logic [XLEN-1:0] b2b_exp [8];

    initial begin
        pre_val = '{32'h0, 32'h101, 32'h102, 32'h103, 32'h104,
                    32'h11, 32'h22, 32'h0, 32'h108};
        b2b_exp = '{32'h101, 32'h102, 32'h103, 32'h104,
                    32'h66, 32'h22, 32'hDEAD, 32'h108};
        for (int i = 0; i < 32; i++) rf[i] = '0;

        rst_n = 1'b0; inValid = 1'b0; inRs1 = '0; inRs2 = '0; inPayload = '0;
        write = 1'b0; wrAddr = '0; wrData = '0; flush = 1'b0; outReady = 1'b0;
        #1;

        // Preload x1..x9 through the write port while in reset.
        for (int i = 1; i <= 9; i++) begin
            write = 1'b1; wrAddr = 5'(i);
            wrData = (i == 9) ? 32'h1 : pre_val[i];
            tick();
        end
        write = 1'b0; wrAddr = '0; wrData = '0;
        tick();

        // ---- reset state ----
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_opA", 64'(opA), 64'd0);
        check("rst_opB", 64'(opB), 64'd0);
        check("rst_payload", outPayload, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_inReady", 64'(inReady), 64'd1);

        // ---- plain read ----
        inValid = 1'b1; inRs1 = 5'd5; inRs2 = 5'd6; inPayload = 64'hABC;
        tick();
        inValid = 1'b0;
        check("plain_outValid", 64'(outValid), 64'd1);
        check("plain_opA", 64'(opA), 64'h11);
        check("plain_opB", 64'(opB), 64'h22);
        check("plain_payload", outPayload, 64'hABC);
        outReady = 1'b1;
        tick();
        check("plain_handoff_empty", 64'(outValid), 64'd0);

        // ---- same-edge bypass ----
        inValid = 1'b1; inRs1 = 5'd7; inRs2 = 5'd0; inPayload = 64'h1;
        write = 1'b1; wrAddr = 5'd7; wrData = 32'hDEAD;
        tick();
        inValid = 1'b0; write = 1'b0;
        check("byp_opA", 64'(opA), 64'hDEAD);
        check("byp_opB_x0", 64'(opB), 64'd0);
        tick();
        inValid = 1'b1; inRs1 = 5'd0; inRs2 = 5'd5; inPayload = 64'h2;
        write = 1'b1; wrAddr = 5'd0; wrData = 32'h5555;
        tick();
        inValid = 1'b0; write = 1'b0;
        check("byp_x0_opA", 64'(opA), 64'd0);
        check("byp_x0_opB", 64'(opB), 64'h11);
        tick();

        // ---- stall coherence ----
        outReady = 1'b0;
        inValid = 1'b1; inRs1 = 5'd5; inRs2 = 5'd9; inPayload = 64'h5A5A;
        tick();
        inValid = 1'b0;
        check("stall_fresh_opB", 64'(opB), 64'h1);
        check("stall_inReady", 64'(inReady), 64'd0);
        write = 1'b1; wrAddr = 5'd5; wrData = 32'h66;   // lands on the FRESH->HELD edge
        tick();
        check("stall1_opA_latewrite", 64'(opA), 64'h66);
        check("stall1_opB", 64'(opB), 64'h1);
        wrAddr = 5'd9; wrData = 32'h55;
        tick();
        check("stall2_opB", 64'(opB), 64'h55);
        check("stall2_opA", 64'(opA), 64'h66);
        wrAddr = 5'd0; wrData = 32'h77;
        tick();
        write = 1'b0;
        check("stall3_x0_opA", 64'(opA), 64'h66);
        check("stall3_x0_opB", 64'(opB), 64'h55);
        check("stall3_payload", outPayload, 64'h5A5A);
        check("stall3_outValid", 64'(outValid), 64'd1);
        outReady = 1'b1;
        tick();
        check("stall_handoff_empty", 64'(outValid), 64'd0);

        // ---- back-to-back ----
        inRs2 = 5'd0;
        for (int k = 1; k <= 8; k++) begin
            inValid = 1'b1; inRs1 = 5'(k); inPayload = 64'(k);
            tick();
            check($sformatf("b2b_valid_%0d", k), 64'(outValid), 64'd1);
            check($sformatf("b2b_opA_%0d", k), 64'(opA), 64'(b2b_exp[k-1]));
        end
        inValid = 1'b0;
        tick();
        check("b2b_drain", 64'(outValid), 64'd0);

        // ---- flush mid-stall ----
        outReady = 1'b0;
        inValid = 1'b1; inRs1 = 5'd1; inRs2 = 5'd2; inPayload = 64'h777;
        tick();
        inValid = 1'b0;
        tick();
        check("fl_held_valid", 64'(outValid), 64'd1);
        flush = 1'b1; inValid = 1'b1; inRs1 = 5'd3; outReady = 1'b1;
        #1;
        check("fl_inReady_ungated", 64'(inReady), 64'd1);
        tick();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        check("fl_outValid", 64'(outValid), 64'd0);
        tick();
        check("fl_not_accepted", 64'(outValid), 64'd0);

        // ---- reset mid-stall ----
        inValid = 1'b1; inRs1 = 5'd2; inRs2 = 5'd3; inPayload = 64'h123;
        tick();
        inValid = 1'b0;
        tick();
        check("rs_held_opA", 64'(opA), 64'h102);
        rst_n = 1'b0;
        tick();
        check("rs_outValid", 64'(outValid), 64'd0);
        check("rs_opA", 64'(opA), 64'd0);
        check("rs_opB", 64'(opB), 64'd0);
        check("rs_payload", outPayload, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rs_inReady", 64'(inReady), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage directly downstream of the 32x32 register file (synchronous read, 1-cycle latency, no write-through, x0 never written).
- Accepts source-register indices from decode over a valid/ready handshake and drives the regfile read ports.
- Bypasses writes that the regfile read misses: a same-cycle write returns old data.
- Latches operands while execute stalls, keeps the latched copies coherent with later writebacks, and passes an opaque payload (PC/instruction) alongside.

Parameters:
XLEN, 32, operand/write data width
PAYLOAD_W, 64, width of pass-through payload

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
inValid  in  1  decode presents request
inReady  out  1  stage can accept this cycle
inRs1  in  5  source register A index
inRs2  in  5  source register B index
inPayload  in  PAYLOAD_W  pass-through data
rdAddrA  out  5  to regfile read port A
rdAddrB  out  5  to regfile read port B
rdDataA  in  XLEN  from regfile port A (valid cycle after address sampled)
rdDataB  in  XLEN  from regfile port B
write  in  1  writeback enable (same signal the regfile sees)
wrAddr  in  5  writeback index
wrData  in  XLEN  writeback data
flush  in  1  synchronous pipeline flush
outValid  out  1  operands valid to execute
outReady  in  1  execute accepts
opA  out  XLEN  operand A
opB  out  XLEN  operand B
outPayload  out  PAYLOAD_W  payload of current entry

Behaviour:
- Effective write (wEff) = write && wrAddr!=0; writes to x0 are ignored everywhere.
- States:
  - EMPTY: no entry.
  - FRESH: entry accepted last edge; operands come from regfile outputs this cycle.
  - HELD: operands in local registers.
- inReady = (state==EMPTY) || outReady, combinational; no dependency on inValid. Accept = inValid && inReady.
- rdAddrA/rdAddrB = inRs1/inRs2 at all times, combinational. The regfile samples them every edge; only accept edges matter.
- Accept edge:
  - Capture rs1, rs2, payload.
  - Capture per-port forward flag fwdX = wEff && wrAddr==rsX, with fwdDataX = wrData (regfile read returns pre-write value).
  - Next state FRESH.
- FRESH outputs:
  - opA = (rs1==0) ? 0 : fwdA ? fwdDataA : rdDataA; same for B.
  - outValid = 1.
- FRESH edge:
  - outReady && accept -> FRESH (new entry).
  - outReady && !accept -> EMPTY.
  - !outReady -> HELD. Latch opA/opB as computed this cycle; then if wEff at this edge matches rsX (rsX!=0), the latched value is wrData instead (later write wins).
- HELD outputs: local registers; outValid = 1.
  - Each edge with wEff && wrAddr==rsX && rsX!=0 replaces held operand X with wrData.
  - Same transitions as FRESH on outReady/accept.
- Latency: accept at edge T -> outValid high in cycle after T. Throughput 1/cycle when outReady held high.
- Simultaneous: output handoff and new accept on the same edge is legal; write at that edge is bypassed into the new entry's forward flag.
- flush (edge, priority over accept/handoff): state -> EMPTY, outValid=0, no accept that edge. inReady is not gated by flush.
- Reset (priority over flush):
  - state EMPTY, outValid 0, opA/opB 0, outPayload 0, forward flags 0.
  - inReady is 1 the cycle after reset deasserts.
  - Reset mid-stall discards the entry.
- outPayload is stable while outValid && !outReady. opA/opB change during a stall only due to matching writebacks.

Test Plan:
- Reset: rst_n=0 two cycles -> outValid=0, opA=opB=0, outPayload=0; after release inReady=1.
- Plain read: preload x5=0x11, x6=0x22. Accept rs1=5, rs2=6, payload=0xABC -> next cycle outValid=1, opA=0x11, opB=0x22, outPayload=0xABC.
- Same-edge bypass: accept rs1=7 while write x7=0xDEAD same edge (regfile returns old 0) -> opA=0xDEAD. Repeat with wrAddr=0, rs1=0 -> opA=0.
- Stall coherence: accept rs2=9 (x9=0x1), outReady=0 three cycles, write x9=0x55 on the 2nd stall edge -> opB=0x1 then 0x55. Write x0 meanwhile -> no change. outReady=1 -> handoff, EMPTY.
- Back-to-back: inValid and outReady high 8 cycles, rs1=1..8 -> 8 consecutive outValid cycles, opA = x1..x8 in order, no bubbles.
- Flush/reset mid-stall: entry HELD, flush=1 with inValid=1 -> outValid=0 next cycle, request not accepted. Same with rst_n=0 -> outputs at reset values.
